// File: rtl/mux_2_bit_pkg.sv
// Shared constants for the registered 2:1 mux: default data width and select encodings.
package mux_2_bit_pkg;

    localparam int   DEF_WIDTH = 1;
    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;

endpackage : mux_2_bit_pkg

// File: rtl/mux_2_bit_reg.sv
// Purpose: single-entry valid/ready output register stage.
// Latency: one cycle from input transfer to out_vld.
// Backpressure: in_rdy = ~out_vld | out_rdy (low in reset); a stalled entry holds stable.
module mux_2_bit_reg
    import mux_2_bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             in_xfer;
    logic             out_xfer;

    // rst_n gates in_rdy so nothing is offered as accepted while reset is held.
    always_comb begin
        in_rdy   = rst_n & (~vld_q | out_rdy);
        in_xfer  = in_vld & in_rdy;
        out_xfer = vld_q & out_rdy;
        vld_d    = vld_q;
        dat_d    = dat_q;
        if (in_xfer) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end else if (out_xfer) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;

endmodule : mux_2_bit_reg

// File: rtl/mux_2_bit.sv
// Purpose: registered 2:1 mux, o = s ? b : a, with valid/ready handshakes.
// Latency: one cycle; full throughput of one transfer per cycle.
// Backpressure: in_ready = ~out_valid | out_ready; inputs ignored while stalled.
module mux_2_bit
    import mux_2_bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] sel_dat;

    // A known select passes only the chosen operand, so X on the other one never reaches o.
    always_comb begin
        sel_dat = a;
        if (s == SEL_B) begin
            sel_dat = b;
        end
    end

    mux_2_bit_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_valid),
        .in_dat  (sel_dat),
        .in_rdy  (in_ready),
        .out_vld (out_valid),
        .out_dat (o),
        .out_rdy (out_ready)
    );

endmodule : mux_2_bit

// File: tb/tb_mux_2_bit.sv
// Bench for mux_2_bit: WIDTH=8 and default WIDTH=1 instances share stimulus and one queue-based reference model.
module tb_mux_2_bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a8, b8;
    logic       s, in_valid, out_ready;

    logic [7:0] o8;
    logic       ov8, ir8;
    logic [0:0] o1;
    logic       ov1, ir1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] last_o;

    mux_2_bit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (ir8),
        .o         (o8),
        .out_valid (ov8),
        .out_ready (out_ready)
    );

    mux_2_bit u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8[0:0]),
        .b         (b8[0:0]),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (ir1),
        .o         (o1),
        .out_valid (ov1),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".o8"}, o8, last_o);
        check({tag, ".ov8"}, {7'd0, ov8}, {7'd0, q.size() != 0});
        check({tag, ".o1"}, {7'd0, o1}, {7'd0, last_o[0]});
        check({tag, ".ov1"}, {7'd0, ov1}, {7'd0, q.size() != 0});
    endtask

    task automatic model_reset();
        q.delete();
        last_o = 8'h00;
    endtask

    // One clock: drive, check in_ready before the edge, advance the model, check outputs after.
    task automatic step(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                        input logic iv, input logic ordy, input string tag);
        logic exp_rdy;
        logic [7:0] r;
        a8 = ai; b8 = bi; s = si; in_valid = iv; out_ready = ordy;
        #1;
        exp_rdy = (q.size() == 0) || ordy;
        check({tag, ".ir8"}, {7'd0, ir8}, {7'd0, exp_rdy});
        check({tag, ".ir1"}, {7'd0, ir1}, {7'd0, exp_rdy});
        @(posedge clk);
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (iv && exp_rdy) begin
            r = si ? bi : ai;
            q.push_back(r);
            last_o = r;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".o8"}, o8, 8'h00);
        check({tag, ".ov8"}, {7'd0, ov8}, 8'h00);
        check({tag, ".ir8"}, {7'd0, ir8}, 8'h00);
        check({tag, ".o1"}, {7'd0, o1}, 8'h00);
        check({tag, ".ov1"}, {7'd0, ov1}, 8'h00);
        check({tag, ".ir1"}, {7'd0, ir1}, 8'h00);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; s = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #2;
        check_reset_state("rst_async");
        @(posedge clk); #1;
        check_reset_state("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel.ir8", {7'd0, ir8}, 8'h01);

        // Select sequence with free-running output.
        step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, "sel1"); check("sel1.lit", {7'd0, o1}, 8'h00);
        step(8'h01, 8'h00, 1'b1, 1'b1, 1'b1, "sel2"); check("sel2.lit", {7'd0, o1}, 8'h00);
        step(8'h01, 8'h01, 1'b1, 1'b1, 1'b1, "sel3"); check("sel3.lit", {7'd0, o1}, 8'h01);
        step(8'h00, 8'h01, 1'b0, 1'b1, 1'b1, "sel4"); check("sel4.lit", {7'd0, o1}, 8'h00);

        // Stall: held result must not move while inputs change.
        step(8'h01, 8'h00, 1'b0, 1'b1, 1'b1, "stl_ld"); check("stl_ld.lit", o8, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step(8'($urandom), 8'h00, 1'b1, 1'b1, 1'b0, "stall");
            check("stall.lit", o8, 8'h01);
            check("stall.ir", {7'd0, ir8}, 8'h00);
        end
        step(8'h55, 8'h22, 1'b1, 1'b1, 1'b1, "stl_rel"); check("stl_rel.lit", o8, 8'h22);

        // Back-to-back with alternating select.
        for (int i = 0; i < 8; i++) begin
            step(8'(i * 17 + 3), 8'(~(i * 17 + 3)), 1'(i % 2), 1'b1, 1'b1, "b2b");
            check("b2b.ov", {7'd0, ov8}, 8'h01);
        end

        // Wide operands, including X on the unselected side.
        step(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1, "w8_b"); check("w8_b.lit", o8, 8'h3C);
        step(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, "w8_a"); check("w8_a.lit", o8, 8'hA5);
        step(8'hA5, 8'hxx, 1'b0, 1'b1, 1'b1, "w8_xb"); check("w8_xb.lit", o8, 8'hA5);
        step(8'hxx, 8'h3C, 1'b1, 1'b1, 1'b1, "w8_xa"); check("w8_xa.lit", o8, 8'h3C);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), "rand");
        end
        step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "drain");

        // Reset pulsed in the middle of a stall.
        step(8'h77, 8'h00, 1'b0, 1'b1, 1'b1, "mrs_ld");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "mrs_hold");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("mrs_async");
        @(posedge clk); #1;
        check_reset_state("mrs_edge");
        #2;
        rst_n = 1'b1;
        #1;
        check("mrs_rel.ir8", {7'd0, ir8}, 8'h01);
        check("mrs_rel.ir1", {7'd0, ir1}, 8'h01);
        step(8'h00, 8'h99, 1'b1, 1'b1, 1'b0, "mrs_post"); check("mrs_post.lit", o8, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_2_bit
